// File: rtl/reg_sequencer.sv
// Instruction sequencer for a small register-file datapath.
// Decodes one IR and walks the read / operate / writeback strobes.
module reg_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  aluop,
  output logic [15:0] sximm8,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_OPERATE,
    S_WRITE_REG,
    S_WRITE_IMM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  logic [2:0] w_opc;
  logic [1:0] w_op;
  logic       w_movi;
  logic       w_movr;
  logic       w_alu;
  logic       w_cmp;

  assign w_opc  = r_ir[15:13];
  assign w_op   = r_ir[12:11];
  assign w_movi = (w_opc == 3'b110) && (w_op == 2'b10);
  assign w_movr = (w_opc == 3'b110) && (w_op == 2'b00);
  assign w_alu  = (w_opc == 3'b101);
  assign w_cmp  = w_alu && (w_op == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && start)
        r_ir <= instr;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT:      w_next = start ? S_DECODE : S_WAIT;
      S_DECODE: begin
        unique case (1'b1)
          w_movi:  w_next = S_WRITE_IMM;
          w_movr:  w_next = S_GET_B;
          w_alu:   w_next = S_GET_A;
          default: w_next = S_ERR;
        endcase
      end
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_OPERATE;
      S_OPERATE:   w_next = w_cmp ? S_DONE : S_WRITE_REG;
      S_WRITE_REG: w_next = S_DONE;
      S_WRITE_IMM: w_next = S_DONE;
      S_DONE:      w_next = S_WAIT;
      S_ERR:       w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  // Moore outputs: every strobe is a function of state and IR only
  always_comb begin
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 2'b00;
    done     = 1'b0;
    err      = 1'b0;
    unique case (r_state)
      S_GET_A: begin
        readnum = r_ir[10:8];
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = r_ir[2:0];
        loadb   = 1'b1;
      end
      S_OPERATE: begin
        loadc = !w_cmp;
        loads = w_cmp;
        asel  = w_movr;
      end
      S_WRITE_REG: begin
        writenum = r_ir[7:5];
        write    = 1'b1;
        vsel     = 2'b00;
      end
      S_WRITE_IMM: begin
        writenum = r_ir[10:8];
        write    = 1'b1;
        vsel     = 2'b10;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign shift  = r_ir[4:3];
  assign aluop  = w_movr ? 2'b00 : w_op;
  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign busy   = (r_state != S_WAIT);

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer: expected per-cycle outputs are
// queued when an instruction is issued and compared cycle by cycle.
module tb_reg_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [15:0] sximm8;
  logic        busy;
  logic        done;
  logic        err;

  reg_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .instr    (instr),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .vsel     (vsel),
    .shift    (shift),
    .aluop    (aluop),
    .sximm8   (sximm8),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic        busy;
    logic        done;
    logic        err;
  } outs_t;

  outs_t q_exp[$];
  string q_tag[$];
  int    checks   = 0;
  int    failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t s;
    s.readnum  = readnum;
    s.writenum = writenum;
    s.write    = write;
    s.loada    = loada;
    s.loadb    = loadb;
    s.loadc    = loadc;
    s.loads    = loads;
    s.asel     = asel;
    s.vsel     = vsel;
    s.shift    = shift;
    s.aluop    = aluop;
    s.sximm8   = sximm8;
    s.busy     = busy;
    s.done     = done;
    s.err      = err;
    return s;
  endfunction

  // Outputs every non-WAIT state shares for a given IR
  function automatic outs_t base(input logic [15:0] ir);
    outs_t e;
    e        = '0;
    e.shift  = ir[4:3];
    e.aluop  = (ir[15:11] == 5'b11000) ? 2'b00 : ir[12:11];
    e.sximm8 = {{8{ir[7]}}, ir[7:0]};
    e.busy   = 1'b1;
    return e;
  endfunction

  task automatic push(input outs_t e, input string tag);
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic push_instr(input logic [15:0] ir, input string nm);
    outs_t      e;
    logic [2:0] opc;
    logic [1:0] op;
    opc = ir[15:13];
    op  = ir[12:11];
    push(base(ir), {nm, "_decode"});
    if (opc == 3'b110 && op == 2'b10) begin
      e = base(ir); e.writenum = ir[10:8]; e.write = 1; e.vsel = 2'b10;
      push(e, {nm, "_wr_imm"});
      e = base(ir); e.done = 1;
      push(e, {nm, "_done"});
    end else if (opc == 3'b110 && op == 2'b00) begin
      e = base(ir); e.readnum = ir[2:0]; e.loadb = 1;
      push(e, {nm, "_get_b"});
      e = base(ir); e.loadc = 1; e.asel = 1;
      push(e, {nm, "_operate"});
      e = base(ir); e.writenum = ir[7:5]; e.write = 1;
      push(e, {nm, "_wr_reg"});
      e = base(ir); e.done = 1;
      push(e, {nm, "_done"});
    end else if (opc == 3'b101) begin
      e = base(ir); e.readnum = ir[10:8]; e.loada = 1;
      push(e, {nm, "_get_a"});
      e = base(ir); e.readnum = ir[2:0]; e.loadb = 1;
      push(e, {nm, "_get_b"});
      e = base(ir);
      if (op == 2'b01) e.loads = 1;
      else e.loadc = 1;
      push(e, {nm, "_operate"});
      if (op != 2'b01) begin
        e = base(ir); e.writenum = ir[7:5]; e.write = 1;
        push(e, {nm, "_wr_reg"});
      end
      e = base(ir); e.done = 1;
      push(e, {nm, "_done"});
    end else begin
      e = base(ir); e.err = 1;
      push(e, {nm, "_err"});
    end
    e = base(ir); e.busy = 0;
    push(e, {nm, "_wait"});
  endtask

  task automatic check_one();
    outs_t got;
    outs_t exp;
    string tag;
    got = sample();
    exp = q_exp.pop_front();
    tag = q_tag.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drain();
    while (q_exp.size() > 0) begin
      @(negedge clk);
      check_one();
    end
  endtask

  task automatic run(input logic [15:0] ir, input string nm);
    push_instr(ir, nm);
    @(posedge clk);
    #1;
    start = 1'b1;
    instr = ir;
    @(posedge clk);
    #1;
    start = 1'b0;
    instr = 16'($urandom);
    drain();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    #2;
    push('0, "reset_async");
    check_one();
    @(negedge clk);
    start = 1'b1;
    instr = 16'hA1A2;
    @(negedge clk);
    push('0, "reset_held");
    check_one();
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(16'hD205, "movi_r2_5");
    run(16'hD3FF, "movi_r3_m1");
    run(16'hA1A2, "add");
    run(16'hA902, "cmp");
    run(16'hE000, "unsup");
    run(16'hC074, "movr");
    run(16'hB1C7, "and");
    run(16'hB84B, "mvn");
    run(16'hC800, "unsup_op01");

    // start held high: exactly one WAIT cycle between instructions
    push_instr(16'hD205, "held_a");
    push_instr(16'hA902, "held_b");
    @(posedge clk);
    #1;
    start = 1'b1;
    instr = 16'hD205;
    @(posedge clk);
    #1;
    instr = 16'hA902;
    while (q_exp.size() > 0) begin
      @(negedge clk);
      check_one();
      if (q_exp.size() == 0) start = 1'b0;
      else if (q_tag[0] == "held_b_wait") instr = 16'h0000;
    end

    // reset asserted in GET_B of an ADD
    push_instr(16'hA1A2, "rst_add");
    @(posedge clk);
    #1;
    start = 1'b1;
    instr = 16'hA1A2;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_one();
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    q_exp.delete();
    q_tag.delete();
    push('0, "rst_mid_instr");
    check_one();
    @(negedge clk);
    push('0, "rst_mid_held");
    check_one();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(16'hD205, "post_rst_movi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
